reg_cmd_deframer: RTL and testbench

REG_CMD_DEFRAMER -- requirements
Module: reg_cmd_deframer

---
 rtl/spi_cmd_pkg.sv | 8 +
 rtl/cmd_tx_shifter.sv | 54 +++++
 rtl/reg_cmd_deframer.sv | 99 +++++++++
 tb/tb_reg_cmd_deframer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_pkg.sv
// spi_cmd_pkg: deframer states, header bit layout and default payload size.
package spi_cmd_pkg;
   typedef enum logic [2:0] {S_IDLE, S_DATA, S_ISSUE, S_READ, S_TX, S_DRAIN} state_e;
   localparam int RW_BIT = 7;
   localparam int ADDR_MSB = 6;
   localparam int ADDR_LSB = 0;
   localparam int DATA_BYTES_DEF = 8;
endpackage

// File: rtl/cmd_tx_shifter.sv
// cmd_tx_shifter: parallel-load read-data serializer, MSB byte first, valid/ready per byte.
module cmd_tx_shifter import spi_cmd_pkg::*; #(
   parameter int N = DATA_BYTES_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clr,
   input  logic           load,
   input  logic [N*8-1:0] din,
   input  logic           tx_ready,
   output logic           tx_valid,
   output logic [7:0]     tx_byte,
   output logic           done
);
   localparam int CW = $clog2(N + 1);
   logic [N*8-1:0] sh_q, sh_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic valid_q, valid_d;
   logic xfer;
   assign xfer = valid_q && tx_ready;
   assign done = xfer && cnt_q == '0 && !clr;
   assign tx_valid = valid_q;
   assign tx_byte = sh_q[N*8-1 -: 8];
   // cnt_q counts bytes still to follow the one currently presented
   always_comb begin
      sh_d = sh_q;
      cnt_d = cnt_q;
      valid_d = valid_q;
      if (clr) begin
         sh_d = '0;
         cnt_d = '0;
         valid_d = 1'b0;
      end else if (load) begin
         sh_d = din;
         cnt_d = CW'(N - 1);
         valid_d = 1'b1;
      end else if (xfer) begin
         sh_d = sh_q << 8;
         cnt_d = cnt_q - 1'b1;
         valid_d = cnt_q != '0;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q <= '0;
         cnt_q <= '0;
         valid_q <= 1'b0;
      end else begin
         sh_q <= sh_d;
         cnt_q <= cnt_d;
         valid_q <= valid_d;
      end
   end
endmodule

// File: rtl/reg_cmd_deframer.sv
// reg_cmd_deframer: turns chip-select framed header/payload bytes into register
// read/write commands and streams read data back, counting aborted frames.
module reg_cmd_deframer import spi_cmd_pkg::*; #(
   parameter int DATA_BYTES = DATA_BYTES_DEF,
   parameter int ABORT_CNT_W = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    frame_start,
   input  logic                    frame_end,
   input  logic                    rx_valid,
   input  logic [7:0]              rx_byte,
   output logic                    rx_ready,
   output logic                    tx_valid,
   output logic [7:0]              tx_byte,
   input  logic                    tx_ready,
   output logic                    cmd_valid,
   output logic                    cmd_rw,
   output logic [6:0]              cmd_addr,
   output logic [DATA_BYTES*8-1:0] cmd_wdata,
   input  logic [DATA_BYTES*8-1:0] cmd_rdata,
   output logic [ABORT_CNT_W-1:0]  abort_count
);
   localparam int W = DATA_BYTES * 8;
   localparam int CW = $clog2(DATA_BYTES + 1);
   state_e state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [6:0] addr_q, addr_d;
   logic [W-1:0] wdata_q, wdata_d;
   logic [ABORT_CNT_W-1:0] abort_q, abort_d;
   logic cmd_valid_q, cmd_valid_d, cmd_rw_q, cmd_rw_d;
   logic rx_acc, frame_evt, in_frame, abort, tx_done;
   assign rx_ready = state_q inside {S_IDLE, S_DATA, S_DRAIN};
   assign rx_acc = rx_valid && rx_ready;
   assign frame_evt = frame_start || frame_end;
   assign in_frame = state_q inside {S_DATA, S_READ, S_TX};
   assign cmd_valid = cmd_valid_q;
   assign cmd_rw = cmd_rw_q;
   assign cmd_addr = addr_q;
   assign cmd_wdata = wdata_q;
   assign abort_count = abort_q;
   cmd_tx_shifter #(.N(DATA_BYTES)) u_tx (
      .clk(clk), .rst_n(rst_n), .clr(frame_evt),
      .load(state_q == S_READ && !frame_evt), .din(cmd_rdata),
      .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_byte(tx_byte), .done(tx_done)
   );
   // Any frame boundary wins over the byte handshake; a write already in ISSUE
   // has its command on the bus this cycle, so it completes rather than aborts.
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      addr_d = addr_q;
      wdata_d = wdata_q;
      abort = 1'b0;
      if (frame_evt) begin
         state_d = S_IDLE;
         abort = in_frame;
      end else begin
         case (state_q)
            S_IDLE: if (rx_acc) begin
               addr_d = rx_byte[ADDR_MSB:ADDR_LSB];
               cnt_d = '0;
               state_d = rx_byte[RW_BIT] ? S_READ : S_DATA;
            end
            S_DATA: if (rx_acc) begin
               wdata_d = W'({wdata_q, rx_byte});
               cnt_d = cnt_q + 1'b1;
               state_d = (cnt_q == CW'(DATA_BYTES - 1)) ? S_ISSUE : S_DATA;
            end
            S_ISSUE: state_d = S_DRAIN;
            S_READ:  state_d = S_TX;
            S_TX:    state_d = tx_done ? S_DRAIN : S_TX;
            default: state_d = state_q;
         endcase
      end
      abort_d = (abort && abort_q != '1) ? abort_q + 1'b1 : abort_q;
      cmd_valid_d = state_d inside {S_ISSUE, S_READ};
      cmd_rw_d = state_d == S_READ;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q <= '0;
         addr_q <= '0;
         wdata_q <= '0;
         abort_q <= '0;
         cmd_valid_q <= 1'b0;
         cmd_rw_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         addr_q <= addr_d;
         wdata_q <= wdata_d;
         abort_q <= abort_d;
         cmd_valid_q <= cmd_valid_d;
         cmd_rw_q <= cmd_rw_d;
      end
   end
endmodule

// File: tb/tb_reg_cmd_deframer.sv
// tb_reg_cmd_deframer: randomized frames checked against a byte-level model of the command protocol.
module tb_reg_cmd_deframer;
   typedef struct packed {logic rw; logic [6:0] addr; logic [63:0] wdata;} cmd_t;
   logic clk = 0, rst_n = 1, frame_start = 0, frame_end = 0, rx_valid = 0, tx_ready = 0;
   logic [7:0] rx_byte = 0;
   logic rx_ready, tx_valid, cmd_valid, cmd_rw;
   logic [7:0] tx_byte, abort_count;
   logic [6:0] cmd_addr;
   logic [63:0] cmd_wdata, cmd_rdata = 0;
   int vectors = 0, miscompares = 0, exp_abort = 0;
   cmd_t cmd_q[$];
   logic [7:0] tx_q[$];

   reg_cmd_deframer dut (
      .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .frame_end(frame_end),
      .rx_valid(rx_valid), .rx_byte(rx_byte), .rx_ready(rx_ready),
      .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready),
      .cmd_valid(cmd_valid), .cmd_rw(cmd_rw), .cmd_addr(cmd_addr),
      .cmd_wdata(cmd_wdata), .cmd_rdata(cmd_rdata), .abort_count(abort_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (rst_n) begin
      if (cmd_valid) cmd_q.push_back({cmd_rw, cmd_addr, cmd_wdata});
      if (tx_valid && tx_ready) tx_q.push_back(tx_byte);
   end

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic pulse_start();
      frame_start = 1; tick(); frame_start = 0;
   endtask

   task automatic pulse_end();
      frame_end = 1; tick(); frame_end = 0;
   endtask

   task automatic send(input logic [7:0] b, input int gap = 0);
      if (gap > 0) tick(gap);
      rx_valid = 1; rx_byte = b; tick(); rx_valid = 0;
   endtask

   function automatic logic [63:0] fold(input logic [7:0] b[$]);
      logic [63:0] w = 0;
      foreach (b[i]) w = (w << 8) | 64'(b[i]);
      return w;
   endfunction

   function automatic logic [7:0] byte_of(input logic [63:0] v, input int i);
      return 8'((v >> (56 - 8 * i)) & 64'hff);
   endfunction

   function automatic int sat_inc(input int a);
      return (a >= 255) ? 255 : a + 1;
   endfunction

   task automatic write_frame(input logic [6:0] addr, input logic [7:0] b[$], input int extra);
      pulse_start();
      send({1'b0, addr}, $urandom_range(0, 2));
      foreach (b[i]) send(b[i], $urandom_range(0, 2));
      tick(3);
      repeat (extra) send(8'($urandom));
      pulse_end();
      tick(2);
   endtask

   task automatic read_frame(input logic [6:0] addr, input logic [63:0] rdata, input bit rnd);
      cmd_rdata = rdata;
      pulse_start();
      send({1'b1, addr});
      for (int i = 0; i < 300 && tx_q.size() < 8; i++) begin
         tx_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         tick();
      end
      tx_ready = 0;
      tick(2);
      pulse_end();
      tick(2);
   endtask

   task automatic test_reset();
      rst_n = 1; #2; rst_n = 0; #2;
      vectors++;
      if (rx_ready !== 1'b1) begin
         miscompares++; $display("FAIL reset_rx_ready got %b want 1", rx_ready);
      end
      vectors++;
      if ({cmd_valid, cmd_rw, cmd_addr, cmd_wdata, tx_valid, tx_byte, abort_count} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs got v=%b rw=%b a=%h w=%h tv=%b tb=%h ab=%h want all 0",
                  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, tx_valid, tx_byte, abort_count);
      end
      tick(2); rst_n = 1; tick();
      exp_abort = 0;
   endtask

   task automatic check_write(input string nm, input logic [6:0] addr, input logic [7:0] b[$]);
      cmd_t exp;
      exp = {1'b0, addr, fold(b)};
      vectors++;
      if (cmd_q.size() !== 1) begin
         miscompares++; $display("FAIL %s_cmd_count got %0d want 1", nm, cmd_q.size());
      end else if (cmd_q[0] !== exp) begin
         miscompares++; $display("FAIL %s_cmd got %h want %h", nm, cmd_q[0], exp);
      end
      vectors++;
      if (abort_count !== 8'(exp_abort)) begin
         miscompares++; $display("FAIL %s_abort got %0d want %0d", nm, abort_count, exp_abort);
      end
   endtask

   task automatic test_write();
      logic [7:0] b[$];
      b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hF0, 8'h00, 8'h10, 8'h00};
      cmd_q.delete();
      write_frame(7'h31, b, 0);
      check_write("write_fixed", 7'h31, b);
      for (int n = 0; n < 6; n++) begin
         logic [6:0] a;
         a = 7'($urandom);
         b.delete();
         repeat (8) b.push_back(8'($urandom));
         cmd_q.delete();
         write_frame(a, b, 0);
         check_write("write_rand", a, b);
      end
   endtask

   task automatic check_read(input string nm, input logic [6:0] addr, input logic [63:0] rdata);
      cmd_t exp;
      exp = {1'b1, addr, 64'h0};
      vectors++;
      if (cmd_q.size() !== 1 || cmd_q[0].rw !== 1'b1 || cmd_q[0].addr !== addr) begin
         miscompares++;
         $display("FAIL %s_cmd count=%0d got %h want rw/addr of %h", nm, cmd_q.size(),
                  cmd_q.size() > 0 ? cmd_q[0] : '0, exp);
      end
      vectors++;
      if (tx_q.size() !== 8) begin
         miscompares++; $display("FAIL %s_tx_count got %0d want 8", nm, tx_q.size());
      end else begin
         for (int i = 0; i < 8; i++) if (tx_q[i] !== byte_of(rdata, i)) begin
            miscompares++;
            $display("FAIL %s_tx_byte%0d got %h want %h", nm, i, tx_q[i], byte_of(rdata, i));
            break;
         end
      end
   endtask

   task automatic test_read();
      cmd_q.delete(); tx_q.delete();
      read_frame(7'h31, 64'h00000000_FFFF0000, 0);
      check_read("read_fixed", 7'h31, 64'h00000000_FFFF0000);
      for (int n = 0; n < 4; n++) begin
         logic [6:0] a;
         logic [63:0] d;
         a = 7'($urandom);
         d = {$urandom, $urandom};
         cmd_q.delete(); tx_q.delete();
         read_frame(a, d, 1);
         check_read("read_rand", a, d);
      end
   endtask

   task automatic test_abort();
      logic [7:0] b[$];
      cmd_q.delete(); tx_q.delete();
      pulse_start();
      send(8'h04);
      repeat (3) send(8'($urandom));
      pulse_end();
      tick(2);
      exp_abort = sat_inc(exp_abort);
      vectors++;
      if (cmd_q.size() !== 0 || abort_count !== 8'(exp_abort)) begin
         miscompares++;
         $display("FAIL abort_data cmds=%0d abort=%0d want cmds=0 abort=%0d",
                  cmd_q.size(), abort_count, exp_abort);
      end
      b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10};
      write_frame(7'h04, b, 0);
      check_write("abort_then_write", 7'h04, b);
      // read aborted while its data is waiting in TX
      cmd_q.delete(); tx_q.delete();
      cmd_rdata = {$urandom, $urandom};
      pulse_start();
      send(8'h85);
      tick(3);
      pulse_end();
      exp_abort = sat_inc(exp_abort);
      tx_ready = 1;
      tick(4);
      tx_ready = 0;
      vectors++;
      if (tx_q.size() !== 0 || tx_valid !== 1'b0 || cmd_q.size() !== 1 || abort_count !== 8'(exp_abort)) begin
         miscompares++;
         $display("FAIL abort_tx txs=%0d tv=%b cmds=%0d abort=%0d want 0 0 1 %0d",
                  tx_q.size(), tx_valid, cmd_q.size(), abort_count, exp_abort);
      end
   endtask

   task automatic test_restart();
      logic [7:0] b[$];
      cmd_q.delete();
      pulse_start();
      send(8'h22);
      repeat (2) send(8'($urandom));
      frame_start = 1; frame_end = 1; tick(); frame_start = 0; frame_end = 0;
      exp_abort = sat_inc(exp_abort);
      repeat (8) b.push_back(8'($urandom));
      send(8'h23);
      foreach (b[i]) send(b[i]);
      tick(3);
      pulse_end();
      tick(2);
      check_write("restart", 7'h23, b);
      // header coinciding with frame_end is dropped
      cmd_q.delete();
      rx_valid = 1; rx_byte = 8'hC4; frame_end = 1; tick();
      rx_valid = 0; frame_end = 0;
      tick(4);
      vectors++;
      if (cmd_q.size() !== 0 || abort_count !== 8'(exp_abort)) begin
         miscompares++;
         $display("FAIL hdr_with_end cmds=%0d abort=%0d want 0 %0d", cmd_q.size(), abort_count, exp_abort);
      end
   endtask

   task automatic test_backpressure();
      logic [63:0] d;
      d = {$urandom, $urandom};
      cmd_rdata = d;
      cmd_q.delete(); tx_q.delete();
      pulse_start();
      send(8'h9A);
      for (int i = 0; i < 50 && tx_q.size() < 3; i++) begin tx_ready = 1; tick(); end
      tx_ready = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         vectors++;
         if (tx_valid !== 1'b1 || tx_byte !== byte_of(d, 3)) begin
            miscompares++;
            $display("FAIL bp_hold c%0d got v=%b b=%h want v=1 b=%h", c, tx_valid, tx_byte, byte_of(d, 3));
         end
      end
      for (int i = 0; i < 50 && tx_q.size() < 8; i++) begin tx_ready = 1; tick(); end
      tx_ready = 0;
      tick(2);
      pulse_end();
      tick(2);
      check_read("backpressure", 7'h1A, d);
   endtask

   task automatic test_trailing();
      logic [7:0] b[$];
      repeat (8) b.push_back(8'($urandom));
      cmd_q.delete();
      write_frame(7'h55, b, 3);
      check_write("trailing", 7'h55, b);
   endtask

   task automatic test_reset_mid();
      logic [7:0] b[$];
      cmd_q.delete(); tx_q.delete();
      cmd_rdata = {$urandom, $urandom};
      pulse_start();
      send(8'hA0);
      tick(2);
      vectors++;
      if (tx_valid !== 1'b1) begin
         miscompares++; $display("FAIL rst_mid_in_tx got tv=%b want 1", tx_valid);
      end
      #2 rst_n = 0; #1;
      vectors++;
      if ({cmd_valid, cmd_rw, cmd_addr, cmd_wdata, tx_valid, tx_byte, abort_count} !== '0 || rx_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_mid_outputs got v=%b tv=%b tb=%h a=%h ab=%h rr=%b want zeros rr=1",
                  cmd_valid, tx_valid, tx_byte, cmd_addr, abort_count, rx_ready);
      end
      tick(2);
      rst_n = 1;
      tick();
      exp_abort = 0;
      cmd_q.delete(); tx_q.delete();
      repeat (8) b.push_back(8'($urandom));
      write_frame(7'h6E, b, 0);
      check_write("after_reset", 7'h6E, b);
   endtask

   task automatic test_saturate();
      for (int n = 0; n < 260; n++) begin
         pulse_start();
         send(8'h11);
         exp_abort = sat_inc(exp_abort);
      end
      pulse_start();
      tick();
      vectors++;
      if (abort_count !== 8'(exp_abort) || exp_abort != 255) begin
         miscompares++; $display("FAIL abort_saturate got %0d want %0d", abort_count, exp_abort);
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_abort();
      test_restart();
      test_backpressure();
      test_trailing();
      test_reset_mid();
      test_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
